// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared ICRC constants, header field mask and byte-wise CRC-32 step.
package lynxTypes;

  localparam int          ICRC_BYTES   = 4;
  localparam int          ICRC_HDR_LEN = 40;
  localparam logic [31:0] ICRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ICRC_INIT    = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] ICRC_POLY_REF = reflect32(ICRC_POLY);

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ ICRC_POLY_REF) : (r >> 1);
    return r;
  endfunction

  // Bytes forced to 0xFF: TOS, TTL, IP checksum, UDP checksum, BTH resv8a.
  function automatic logic [319:0] hdr_mask();
    logic [319:0] m;
    m = '0;
    m[1*8 +: 8]   = 8'hFF;
    m[8*8 +: 8]   = 8'hFF;
    m[10*8 +: 16] = 16'hFFFF;
    m[26*8 +: 16] = 16'hFFFF;
    m[32*8 +: 8]  = 8'hFF;
    return m;
  endfunction

  localparam logic [319:0] ICRC_HDR_MASK = hdr_mask();

  // CRC state after the 8-byte 0xFF pseudo-header that precedes every packet.
  function automatic logic [31:0] crc_seed();
    logic [31:0] c;
    c = ICRC_INIT;
    for (int i = 0; i < 8; i++) c = crc32_byte(c, 8'hFF);
    return c;
  endfunction

  localparam logic [31:0] ICRC_SEED = crc_seed();

endpackage

// File: rtl/AXI4S.sv
// rtl/AXI4S.sv - AXI4-Stream bundle with master/slave views.
interface AXI4S #(
  parameter int DATA_BITS = 512
) ();
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport m (output tdata, tkeep, tlast, tvalid, input tready);
  modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/crc32_beat.sv
// rtl/crc32_beat.sv - combinational CRC-32 over the enabled bytes of one beat, byte 0 first.
module crc32_beat
  import lynxTypes::*;
#(
  parameter int DATA_BITS = 512
) (
  input  logic [31:0]            crc_in,
  input  logic [DATA_BITS-1:0]   data,
  input  logic [DATA_BITS/8-1:0] be,
  output logic [31:0]            crc_out
);
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < DATA_BITS / 8; b++) begin
      if (be[b]) c = crc32_byte(c, data[b*8 +: 8]);
    end
    crc_out = c;
  end
endmodule

// File: rtl/roce_icrc_check.sv
// rtl/roce_icrc_check.sv - RoCEv2 ICRC checker with a one-beat hold register.
// Define ICRC_STRIP_EN to remove the 4 ICRC bytes from the forwarded stream.
module roce_icrc_check
  import lynxTypes::*;
#(
  parameter int DATA_BITS = 512
) (
  input  logic        nclk,
  input  logic        nreset,
  AXI4S.s             s_axis_rx,
  AXI4S.m             m_axis_rx,
  output logic        icrc_err,
  output logic [31:0] pkt_cnt,
  output logic [31:0] err_cnt
);
  localparam int BYTES = DATA_BITS / 8;
`ifdef ICRC_STRIP_EN
  localparam bit STRIP_EN = 1'b1;
`else
  localparam bit STRIP_EN = 1'b0;
`endif

  logic                   held_valid, held_last, held_err;
  logic [DATA_BITS-1:0]   held_data;
  logic [BYTES-1:0]       held_keep;
  logic [15:0]            held_off;
  logic [31:0]            crc;

  logic                   prev, accept, drop, bad, out_fire;
  int                     n_in, h_cut;
  logic [BYTES-1:0]       h_be, x_be;
  logic [15:0]            x_off;
  logic [31:0]            h_base, x_base, c1, c2, rx_icrc;
  logic [DATA_BITS-1:0]   h_masked, x_masked;
  logic [2*DATA_BITS-1:0] cat;

  function automatic logic [DATA_BITS-1:0] apply_mask(input logic [DATA_BITS-1:0] d,
                                                      input logic [15:0] off);
    logic [DATA_BITS-1:0] r;
    r = d;
    for (int b = 0; b < BYTES; b++) begin
      if (int'(off) + b < ICRC_HDR_LEN)
        r[b*8 +: 8] = r[b*8 +: 8] | ICRC_HDR_MASK[(int'(off) + b)*8 +: 8];
    end
    return r;
  endfunction

  // A non-last held beat stays in CRC limbo until we know whether its tail is ICRC.
  assign prev = held_valid && !held_last;

  always_comb begin
    n_in = 0;
    for (int b = 0; b < BYTES; b++) if (s_axis_rx.tkeep[b]) n_in = n_in + 1;
    h_cut = (s_axis_rx.tlast && n_in < ICRC_BYTES) ? ICRC_BYTES - n_in : 0;
    for (int b = 0; b < BYTES; b++) begin
      h_be[b] = prev && held_keep[b] && (b < BYTES - h_cut);
      x_be[b] = s_axis_rx.tlast && s_axis_rx.tkeep[b] && (b < n_in - ICRC_BYTES);
    end
    x_off = '0;
    if (prev) x_off = (held_off >= 16'(ICRC_HDR_LEN)) ? held_off : held_off + 16'(BYTES);
    h_base = (held_off == '0) ? ICRC_SEED : crc;
  end

  assign h_masked = apply_mask(held_data, held_off);
  assign x_masked = apply_mask(s_axis_rx.tdata, x_off);

  crc32_beat #(.DATA_BITS(DATA_BITS)) u_crc_held (
    .crc_in(h_base), .data(h_masked), .be(h_be), .crc_out(c1)
  );

  assign x_base = prev ? c1 : ICRC_SEED;

  crc32_beat #(.DATA_BITS(DATA_BITS)) u_crc_in (
    .crc_in(x_base), .data(x_masked), .be(x_be), .crc_out(c2)
  );

  // Received ICRC is the last 4 valid bytes of {incoming, held}; may straddle both.
  assign cat     = {s_axis_rx.tdata, prev ? held_data : {DATA_BITS{1'b0}}};
  assign rx_icrc = cat[(BYTES + n_in - ICRC_BYTES)*8 +: 32];
  assign bad     = s_axis_rx.tlast && (~c2 != rx_icrc);
  assign drop    = STRIP_EN && prev && s_axis_rx.tvalid && s_axis_rx.tlast && (n_in <= ICRC_BYTES);

  assign s_axis_rx.tready = !nreset && (!held_valid || m_axis_rx.tready);
  assign accept           = s_axis_rx.tvalid && s_axis_rx.tready;

  assign m_axis_rx.tvalid = held_valid && (held_last || s_axis_rx.tvalid);
  assign m_axis_rx.tdata  = held_data;
  assign m_axis_rx.tkeep  = drop ? h_be : held_keep;
  assign m_axis_rx.tlast  = held_last || drop;
  assign icrc_err         = (held_valid && held_last && held_err) || (drop && bad);
  assign out_fire         = m_axis_rx.tvalid && m_axis_rx.tready && m_axis_rx.tlast;

  always_ff @(posedge nclk or posedge nreset) begin
    if (nreset) begin
      held_valid <= 1'b0;
      held_last  <= 1'b0;
      held_err   <= 1'b0;
      held_data  <= '0;
      held_keep  <= '0;
      held_off   <= '0;
      crc        <= ICRC_INIT;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept) begin
        if (drop) begin
          held_valid <= 1'b0;
          held_last  <= 1'b0;
          held_err   <= 1'b0;
          crc        <= ICRC_INIT;
        end else begin
          held_valid <= 1'b1;
          held_data  <= s_axis_rx.tdata;
          held_keep  <= (STRIP_EN && s_axis_rx.tlast) ? x_be : s_axis_rx.tkeep;
          held_last  <= s_axis_rx.tlast;
          held_err   <= bad;
          held_off   <= x_off;
          crc        <= s_axis_rx.tlast ? ICRC_INIT : (prev ? c1 : crc);
        end
      end else if (out_fire) begin
        held_valid <= 1'b0;
        held_last  <= 1'b0;
        held_err   <= 1'b0;
      end
      if (out_fire) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        if (icrc_err) err_cnt <= err_cnt + 32'd1;
      end
    end
  end
endmodule
